// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the CPU front end: opcodes, instruction field positions,
// decoded-field bundle and fetch FSM state encoding.
package fetch_decode_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,
    OP_OR   = 5'd4,  OP_XOR  = 5'd5,  OP_NOT  = 5'd6,  OP_SHL  = 5'd7,
    OP_SHR  = 5'd8,  OP_LD   = 5'd9,  OP_ST   = 5'd10, OP_MOV  = 5'd11,
    OP_JMP  = 5'd12, OP_JGO  = 5'd13, OP_JLO  = 5'd14, OP_JEO  = 5'd15,
    OP_HLT  = 5'd16, OP_RST  = 5'd17, OP_SETH = 5'd18, OP_SETL = 5'd19
  } opcode_e;

  localparam int unsigned OPP_HI = 15;
  localparam int unsigned OPP_LO = 11;
  localparam int unsigned R1_HI  = 10;
  localparam int unsigned R1_LO  = 8;
  localparam int unsigned R2_HI  = 7;
  localparam int unsigned R2_LO  = 5;
  localparam int unsigned QR_HI  = 4;
  localparam int unsigned QR_LO  = 2;
  localparam int unsigned RES_HI = 1;
  localparam int unsigned RES_LO = 0;

  typedef struct packed {
    logic [4:0] opp;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] qr;
    logic [1:0] res;
    logic       illegal;
  } dec_fields_t;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  function automatic logic is_illegal(input logic [4:0] op);
    return op > OP_SETL;
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Front-end bus bundle: instruction-memory request/response and the decoded
// instruction handshake toward the control unit.
interface fetch_decode_if #(
  parameter int PC_WIDTH = 16
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_rvalid;
  logic [15:0]         imem_rdata;
  logic                dec_valid;
  logic                dec_ready;
  logic [4:0]          opp;
  logic [2:0]          r1;
  logic [2:0]          r2;
  logic [2:0]          qr;
  logic [1:0]          res;
  logic [PC_WIDTH-1:0] dec_pc;
  logic                dec_illegal;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output dec_valid, opp, r1, r2, qr, res, dec_pc, dec_illegal,
    input  dec_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  dec_valid, opp, r1, r2, qr, res, dec_pc, dec_illegal,
    output dec_ready
  );
endinterface

// File: rtl/fetch_decode_instr_decode.sv
// Splits a 16-bit instruction word into its fields; opcodes above SETL are
// flagged illegal and replaced by NOP so downstream logic sees a harmless op.
module instr_decode
  import fetch_decode_pkg::*;
(
  input  logic [15:0]  instr,
  output dec_fields_t  fields
);

  logic [4:0] opp_raw;
  logic       ill;

  always_comb begin
    fields         = '0;
    opp_raw        = instr[OPP_HI:OPP_LO];
    ill            = is_illegal(opp_raw);
    fields.opp     = ill ? OP_NOP : opp_raw;
    fields.r1      = instr[R1_HI:R1_LO];
    fields.r2      = instr[R2_HI:R2_LO];
    fields.qr      = instr[QR_HI:QR_LO];
    fields.res     = instr[RES_HI:RES_LO];
    fields.illegal = ill;
  end

endmodule

// File: rtl/fetch_decode.sv
// CPU front end: owns the PC, fetches one word at a time and issues decoded
// fields over valid/ready, reacting to branch redirects, HLT and RST.
//
// state | meaning
// FETCH | imem_req high for one cycle at pc
// WAIT  | request outstanding, latch fields on imem_rvalid
// ISSUE | dec_valid high until accepted
// HALT  | HLT accepted, idle until resume
// DRAIN | redirected with a fetch in flight, swallow its response
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
)(
  input  logic                clk,
  input  logic                rst_n,
  fetch_decode_if.master      bus,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                resume,
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] dec_pc_q, dec_pc_d;
  dec_fields_t         fields_q, fields_d;
  dec_fields_t         word_fields;

  instr_decode u_instr_decode (
    .instr  (bus.imem_rdata),
    .fields (word_fields)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      dec_pc_q <= '0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      dec_pc_q <= dec_pc_d;
      fields_q <= fields_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    dec_pc_d = dec_pc_q;
    fields_d = fields_q;
    unique case (state_q)
      S_FETCH: state_d = br_taken ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (br_taken) begin
            state_d = S_FETCH;
          end else begin
            state_d  = S_ISSUE;
            fields_d = word_fields;
            dec_pc_d = pc_q;
          end
        end else if (br_taken) begin
          state_d = S_DRAIN;
        end
      end
      S_ISSUE: begin
        if (br_taken) begin
          state_d = S_FETCH;
        end else if (bus.dec_ready) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
          if (fields_q.opp == OP_HLT) begin
            state_d = S_HALT;
          end else if (fields_q.opp == OP_RST) begin
            pc_d = RESET_PC;
          end
        end
      end
      S_HALT:  if (resume) state_d = S_FETCH;
      S_DRAIN: if (bus.imem_rvalid) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
    // Redirect overrides any state-local PC update; a halted core ignores it.
    if (br_taken && (state_q != S_HALT)) begin
      pc_d = br_target;
    end
  end

  assign bus.imem_req    = rst_n && (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.dec_valid   = (state_q == S_ISSUE) && !br_taken;
  assign bus.opp         = fields_q.opp;
  assign bus.r1          = fields_q.r1;
  assign bus.r2          = fields_q.r2;
  assign bus.qr          = fields_q.qr;
  assign bus.res         = fields_q.res;
  assign bus.dec_illegal = fields_q.illegal;
  assign bus.dec_pc      = dec_pc_q;
  assign halted          = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: variable-latency instruction memory model plus a
// scoreboard of expected issued instructions checked on every acceptance.
module tb_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        br_taken;
  logic [15:0] br_target;
  logic        resume;
  logic        halted;

  fetch_decode_if #(.PC_WIDTH(16)) bus ();

  fetch_decode #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .br_taken  (br_taken),
    .br_target (br_target),
    .resume    (resume),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {opp, r1, r2, qr, res, illegal, dec_pc} as seen on the outputs
  logic [63:0] obs;
  assign obs = {31'b0, bus.opp, bus.r1, bus.r2, bus.qr, bus.res, bus.dec_illegal, bus.dec_pc};

  function automatic logic [63:0] exp_issue(input logic [15:0] w, input logic [15:0] pc);
    logic [4:0] op;
    logic       ill;
    op  = w[15:11];
    ill = (op >= 5'd20);
    return {31'b0, (ill ? 5'd0 : op), w[10:8], w[7:5], w[4:2], w[1:0], ill, pc};
  endfunction

  logic [63:0] sb_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.dec_valid && bus.dec_ready) begin
      chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) chk("sb_issue", obs, sb_q.pop_front());
    end
  end

  logic [15:0] mem [0:65535];
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [15:0] req_addr = 16'h0;

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem[req_addr];
          pend            = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (bus.imem_req) begin
        chk("req_while_pending", 64'(pend), 64'd0);
        pend     = 1'b1;
        cnt      = lat;
        req_addr = bus.imem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!bus.dec_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.dec_valid), 64'd1);
  endtask

  task automatic wait_req(input string tag, input logic [15:0] a);
    int n;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 64'(bus.imem_req), 64'd1);
    chk({tag, "_addr"}, 64'(bus.imem_addr), 64'(a));
  endtask

  task automatic accept_one();
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(bus.imem_req), 64'd0);
    chk({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
    chk({tag, "_valid"}, 64'(bus.dec_valid), 64'd0);
    chk({tag, "_fields"}, obs, 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
  endtask

  initial begin
    int n;
    int stale;
    int reqs;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0A5B;
    mem[16'h0001] = 16'h1234;
    mem[16'h0040] = 16'hF800;
    mem[16'h0005] = 16'h8000;
    mem[16'h0006] = 16'h8800;
    mem[16'hFFFF] = 16'h2000;

    rst_n = 1'b0; br_taken = 1'b0; br_target = 16'h0; resume = 1'b0;
    bus.dec_ready = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");

    // first fetch after reset, 1-cycle memory
    rst_n = 1'b1;
    wait_valid("t1", n);
    chk("t1_latency", 64'(n), 64'd2);
    chk("t1_opp", 64'(bus.opp), 64'd1);
    chk("t1_r1", 64'(bus.r1), 64'd2);
    chk("t1_r2", 64'(bus.r2), 64'd2);
    chk("t1_qr", 64'(bus.qr), 64'd6);
    chk("t1_res", 64'(bus.res), 64'd3);
    chk("t1_pc", 64'(bus.dec_pc), 64'd0);
    chk("t1_illegal", 64'(bus.dec_illegal), 64'd0);

    // back-pressure: output must hold
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 64'(bus.dec_valid), 64'd1);
      chk("t2_hold_fields", obs, exp_issue(16'h0A5B, 16'h0000));
      chk("t2_hold_no_req", 64'(bus.imem_req), 64'd0);
    end
    sb_q.push_back(exp_issue(16'h0A5B, 16'h0000));
    accept_one();
    chk("t2_next_req", 64'(bus.imem_req), 64'd1);
    chk("t2_next_addr", 64'(bus.imem_addr), 64'd1);
    wait_valid("t2b", n);
    lat = 4;
    sb_q.push_back(exp_issue(16'h1234, 16'h0001));
    accept_one();

    // redirect while a slow fetch is outstanding
    chk("t3_fetch_addr", 64'(bus.imem_addr), 64'd2);
    tick();
    br_target = 16'h0040;
    br_taken  = 1'b1;
    tick();
    br_taken  = 1'b0;
    lat       = 1;
    stale = 0;
    n     = 0;
    while (!bus.imem_req && n < 20) begin
      if (bus.dec_valid) stale++;
      tick();
      n++;
    end
    chk("t3_no_stale_issue", 64'(stale), 64'd0);
    chk("t3_redirect_req", 64'(bus.imem_req), 64'd1);
    chk("t3_redirect_addr", 64'(bus.imem_addr), 64'h40);

    // illegal opcode becomes NOP
    wait_valid("t5", n);
    chk("t5_opp_nop", 64'(bus.opp), 64'd0);
    chk("t5_illegal", 64'(bus.dec_illegal), 64'd1);
    chk("t5_pc", 64'(bus.dec_pc), 64'h40);

    // branch while issuing kills dec_valid in the same cycle
    br_target     = 16'h0005;
    br_taken      = 1'b1;
    bus.dec_ready = 1'b1;
    #1;
    chk("br_issue_kills_valid", 64'(bus.dec_valid), 64'd0);
    tick();
    br_taken      = 1'b0;
    bus.dec_ready = 1'b0;
    wait_req("t4_br", 16'h0005);

    // HLT, ignored branch while halted, resume
    wait_valid("t4", n);
    chk("t4_opp_hlt", 64'(bus.opp), 64'd16);
    sb_q.push_back(exp_issue(16'h8000, 16'h0005));
    accept_one();
    chk("t4_halted", 64'(halted), 64'd1);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        br_target = 16'h0099;
        br_taken  = 1'b1;
      end
      if (i == 4) br_taken = 1'b0;
      if (bus.imem_req) reqs++;
      tick();
    end
    chk("t4_no_req_in_halt", 64'(reqs), 64'd0);
    chk("t4_still_halted", 64'(halted), 64'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("t4_resumed", 64'(halted), 64'd0);
    wait_req("t4_resume", 16'h0006);

    // RST instruction returns to the reset PC
    wait_valid("t5_rst", n);
    chk("t5_rst_opp", 64'(bus.opp), 64'd17);
    sb_q.push_back(exp_issue(16'h8800, 16'h0006));
    accept_one();
    wait_req("t5_rst", 16'h0000);

    // PC wrap at FFFF
    wait_valid("t6a", n);
    br_target = 16'hFFFF;
    br_taken  = 1'b1;
    tick();
    br_taken  = 1'b0;
    wait_req("t6_br", 16'hFFFF);
    wait_valid("t6_top", n);
    chk("t6_top_pc", 64'(bus.dec_pc), 64'hFFFF);
    lat = 3;
    sb_q.push_back(exp_issue(16'h2000, 16'hFFFF));
    accept_one();
    wait_req("t6_wrap", 16'h0000);

    // asynchronous reset in WAIT
    tick();
    chk("t6_in_wait", 64'(bus.imem_req), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async_rst");
    tick();
    tick();
    lat   = 1;
    rst_n = 1'b1;
    wait_valid("t6_after_rst", n);
    chk("t6_after_rst_latency", 64'(n), 64'd2);
    chk("t6_after_rst_fields", obs, exp_issue(16'h0A5B, 16'h0000));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
